// File: rtl/bfp_block_normalizer.sv
// bfp_block_normalizer
//   Collects BEATS beats of P IEEE-style floats into a single buffer, tracks the
//   largest biased exponent over the whole vector, then drains the vector as block
//   floating point: one shared exponent plus a right-aligned, optionally rounded
//   BFPM-bit magnitude and a sign per lane.
//
// Ports
//   clk, reset     clock, synchronous active-high reset
//   in_valid/ready input beat handshake (ready only while filling)
//   in_data        P lanes of BIT-bit floats, lane j = in_data[j*BIT +: BIT]
//   out_valid/ready output beat handshake (valid only while draining)
//   out_sign       per-lane sign bits
//   out_mant       per-lane magnitudes, lane j = out_mant[j*BFPM +: BFPM]
//   out_exp        shared exponent, unbiased two's complement
//   out_last       final beat of the vector
//   out_special    vector contained Inf/NaN (held for every beat of the vector)
module bfp_block_normalizer #(
   parameter int P     = 4,
   parameter int BEATS = 2,
   parameter int BIT   = 32,
   parameter int FPM   = 23,
   parameter int BFPM  = 8,
   parameter int RND   = 1
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                in_valid,
   output logic                in_ready,
   input  logic [P*BIT-1:0]    in_data,
   output logic                out_valid,
   input  logic                out_ready,
   output logic [P-1:0]        out_sign,
   output logic [P*BFPM-1:0]   out_mant,
   output logic [BIT-FPM-2:0]  out_exp,
   output logic                out_last,
   output logic                out_special
);

   localparam int EXP  = BIT - FPM - 1;
   localparam int BIAS = 2 ** (EXP - 1) - 1;
   localparam int CW   = (BEATS > 1) ? $clog2(BEATS) : 1;

   localparam logic [CW-1:0]  CNT_LAST = CW'(BEATS - 1);
   localparam logic [EXP-1:0] BFPM_E   = EXP'(BFPM);
   localparam logic [EXP-1:0] BIAS_E   = EXP'(BIAS);

   typedef enum logic {StFill, StDrain} state_e;

   state_e             state_q, state_d;
   logic [CW-1:0]      cnt_q, cnt_d;
   logic [EXP-1:0]     max_q, max_d;
   logic               special_q, special_d;
   logic [P*BIT-1:0]   buf_q [BEATS];

   // Exponent scan of the incoming beat.
   logic [EXP-1:0]     beat_max;
   logic               beat_special;
   logic [EXP-1:0]     in_e;

   always_comb begin
      beat_max     = max_q;
      beat_special = 1'b0;
      in_e         = '0;
      for (int j = 0; j < P; j++) begin
         in_e = in_data[j*BIT+FPM +: EXP];
         if (in_e == '1) begin
            beat_special = 1'b1;
         end else if ((in_e != '0) && (in_e > beat_max)) begin
            beat_max = in_e;
         end
      end
   end

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      max_d     = max_q;
      special_d = special_q;
      unique case (state_q)
         StFill: begin
            if (in_valid) begin
               max_d     = beat_max;
               special_d = special_q | beat_special;
               if (cnt_q == CNT_LAST) begin
                  cnt_d   = '0;
                  state_d = StDrain;
               end else begin
                  cnt_d = cnt_q + CW'(1);
               end
            end
         end
         StDrain: begin
            if (out_ready) begin
               if (cnt_q == CNT_LAST) begin
                  cnt_d     = '0;
                  max_d     = '0;
                  special_d = 1'b0;
                  state_d   = StFill;
               end else begin
                  cnt_d = cnt_q + CW'(1);
               end
            end
         end
         default: state_d = StFill;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q   <= StFill;
         cnt_q     <= '0;
         max_q     <= '0;
         special_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         max_q     <= max_d;
         special_q <= special_d;
      end
   end

   // Buffer contents are don't-care after reset, so no reset here.
   always_ff @(posedge clk) begin
      if ((state_q == StFill) && in_valid) begin
         buf_q[cnt_q] <= in_data;
      end
   end

   // Output conversion of the beat currently addressed by cnt_q.
   logic               draining;
   logic [P*BIT-1:0]   cur;
   logic [EXP-1:0]     lane_e;
   logic [FPM-1:0]     lane_f;
   logic [EXP-1:0]     lane_sh;
   logic [BFPM:0]      lane_ext;
   logic [BFPM:0]      lane_shifted;
   logic [BFPM:0]      lane_sum;
   logic [BFPM-1:0]    lane_mant;

   assign draining  = (state_q == StDrain);
   assign in_ready  = ~draining;
   assign out_valid = draining;
   assign out_last  = draining && (cnt_q == CNT_LAST);
   assign out_special = draining && special_q;
   assign out_exp   = (draining && (max_q != '0)) ? (max_q - BIAS_E) : '0;
   assign cur       = buf_q[cnt_q];

   always_comb begin
      out_sign     = '0;
      out_mant     = '0;
      lane_e       = '0;
      lane_f       = '0;
      lane_sh      = '0;
      lane_ext     = '0;
      lane_shifted = '0;
      lane_sum     = '0;
      lane_mant    = '0;
      for (int j = 0; j < P; j++) begin
         lane_e  = cur[j*BIT+FPM +: EXP];
         lane_f  = cur[j*BIT +: FPM];
         lane_sh = max_q - lane_e;
         // Hidden one, BFPM-1 kept fraction bits, then the first dropped (guard) bit.
         lane_ext     = {1'b1, lane_f[FPM-1 -: BFPM]};
         lane_shifted = lane_ext >> lane_sh;
         if (RND != 0) begin
            lane_sum  = {1'b0, lane_shifted[BFPM:1]} + {{BFPM{1'b0}}, lane_shifted[0]};
            lane_mant = lane_sum[BFPM] ? '1 : lane_sum[BFPM-1:0];
         end else begin
            lane_mant = lane_shifted[BFPM:1];
         end
         if ((lane_e == '0) || (lane_e == '1) || (lane_sh >= BFPM_E) || !draining) begin
            lane_mant = '0;
         end
         out_sign[j]              = draining & cur[j*BIT+BIT-1];
         out_mant[j*BFPM +: BFPM] = lane_mant;
      end
   end

endmodule

// File: tb/tb_bfp_block_normalizer.sv
module tb_bfp_block_normalizer;

   localparam int P     = 4;
   localparam int BEATS = 2;
   localparam int BIT   = 32;
   localparam int FPM   = 23;
   localparam int BFPM  = 8;
   localparam int EXP   = 8;
   localparam int BIAS  = 127;
   localparam int V     = P * BEATS;

   logic              clk = 1'b0;
   logic              reset;
   logic              in_valid;
   logic              out_ready;
   logic [P*BIT-1:0]  in_data;

   logic              in_ready_r, out_valid_r, out_last_r, out_special_r;
   logic [P-1:0]      out_sign_r;
   logic [P*BFPM-1:0] out_mant_r;
   logic [EXP-1:0]    out_exp_r;

   logic              in_ready_t, out_valid_t, out_last_t, out_special_t;
   logic [P-1:0]      out_sign_t;
   logic [P*BFPM-1:0] out_mant_t;
   logic [EXP-1:0]    out_exp_t;

   always #5 clk = ~clk;

   bfp_block_normalizer #(.P(P), .BEATS(BEATS), .BIT(BIT), .FPM(FPM), .BFPM(BFPM), .RND(1))
   dut (
      .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready_r), .in_data(in_data),
      .out_valid(out_valid_r), .out_ready(out_ready), .out_sign(out_sign_r),
      .out_mant(out_mant_r), .out_exp(out_exp_r), .out_last(out_last_r),
      .out_special(out_special_r)
   );

   bfp_block_normalizer #(.P(P), .BEATS(BEATS), .BIT(BIT), .FPM(FPM), .BFPM(BFPM), .RND(0))
   dut_trunc (
      .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready_t), .in_data(in_data),
      .out_valid(out_valid_t), .out_ready(out_ready), .out_sign(out_sign_t),
      .out_mant(out_mant_t), .out_exp(out_exp_t), .out_last(out_last_t),
      .out_special(out_special_t)
   );

   int n_checks = 0;
   int n_pass   = 0;
   logic [31:0] vec [V];

   task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] expv);
      n_checks++;
      if (obs === expv) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", tag, obs, expv);
   endtask

   // Reference: exact significand scaled so the result keeps BFPM bits at the shared
   // exponent; everything below is dropped, the highest dropped bit decides rounding.
   function automatic int ref_mant(input logic [31:0] f, input int mx, input bit rnd);
      int e, sh, total;
      longint full, q;
      e = int'(f[30:23]);
      if (e == 0 || e == 255) return 0;
      sh = mx - e;
      if (sh >= BFPM) return 0;
      full  = longint'({1'b1, f[22:0]});
      total = sh + (FPM + 1 - BFPM);
      q = full >> total;
      if (rnd && (((full >> (total - 1)) & 1) == 1)) q = q + 1;
      if (q > 255) q = 255;
      return int'(q);
   endfunction

   task automatic vec_ref(output int mx, output bit sp);
      int e;
      mx = 0;
      sp = 1'b0;
      for (int i = 0; i < V; i++) begin
         e = int'(vec[i][30:23]);
         if (e == 255) sp = 1'b1;
         else if (e > mx) mx = e;
      end
   endtask

   task automatic check_beat(input int b, input int mx, input bit sp);
      logic [31:0] em1, em0;
      logic [3:0]  es;
      logic [7:0]  ee;
      for (int j = 0; j < P; j++) begin
         em1[j*8 +: 8] = 8'(ref_mant(vec[b*P+j], mx, 1'b1));
         em0[j*8 +: 8] = 8'(ref_mant(vec[b*P+j], mx, 1'b0));
         es[j]         = vec[b*P+j][31];
      end
      ee = (mx == 0) ? 8'h00 : 8'(mx - BIAS);
      check_eq("drain_valid", {out_valid_r, out_valid_t}, 2'b11);
      check_eq("drain_in_ready", {in_ready_r, in_ready_t}, 2'b00);
      check_eq("out_last", out_last_r, (b == BEATS - 1));
      check_eq("out_exp", out_exp_r, ee);
      check_eq("out_exp_trunc", out_exp_t, ee);
      check_eq("out_special", {out_special_r, out_special_t}, {sp, sp});
      check_eq("out_sign", out_sign_r, es);
      check_eq("out_mant_rnd", out_mant_r, em1);
      check_eq("out_mant_trunc", out_mant_t, em0);
   endtask

   // Fill with random gaps, then drain with an optional initial stall and random stalls.
   // With abort set, reset is pulsed right after the first output beat is taken.
   task automatic run_vector(input int gap_max, input int hold_len, input bit abort);
      int mx, b, holds, budget;
      bit sp, rdy;
      vec_ref(mx, sp);
      for (int bt = 0; bt < BEATS; bt++) begin
         for (int g = 0; g < int'($urandom_range(0, gap_max)); g++) begin
            @(negedge clk);
            in_valid = 1'b0;
            check_eq("fill_ready", {in_ready_r, out_valid_r}, 2'b10);
         end
         @(negedge clk);
         check_eq("fill_ready", {in_ready_r, out_valid_r}, 2'b10);
         in_valid = 1'b1;
         for (int j = 0; j < P; j++) in_data[j*BIT +: BIT] = vec[bt*P+j];
      end
      @(negedge clk);
      in_valid = 1'b0;
      in_data  = '0;
      check_eq("first_out_latency", out_valid_r, 1'b1);
      b = 0;
      holds = 0;
      budget = 0;
      while (b < BEATS) begin
         if (budget > 200) begin
            check_eq("drain_timeout", budget, 0);
            break;
         end
         budget++;
         check_beat(b, mx, sp);
         if (holds < hold_len) begin
            rdy = 1'b0;
            holds++;
         end else begin
            rdy = ($urandom_range(0, 3) != 0);
         end
         out_ready = rdy;
         @(negedge clk);
         if (rdy) b++;
         if (abort && b == 1) begin
            out_ready = 1'b0;
            reset = 1'b1;
            @(negedge clk);
            reset = 1'b0;
            check_eq("abort_valid", out_valid_r, 1'b0);
            check_eq("abort_ready", in_ready_r, 1'b1);
            check_eq("abort_exp", out_exp_r, 8'h00);
            check_eq("abort_last_special", {out_last_r, out_special_r}, 2'b00);
            return;
         end
      end
      out_ready = 1'b0;
      check_eq("back_to_fill", {in_ready_r, out_valid_r}, 2'b10);
   endtask

   task automatic set_vec(input logic [31:0] a0, input logic [31:0] a1,
                          input logic [31:0] a2, input logic [31:0] a3);
      vec[0] = a0; vec[1] = a1; vec[2] = a2; vec[3] = a3;
      for (int i = P; i < V; i++) vec[i] = 32'h0;
   endtask

   task automatic rand_vec(input bit allow_special);
      int r;
      logic [7:0] e;
      for (int i = 0; i < V; i++) begin
         r = int'($urandom_range(0, 15));
         if (r == 0) e = 8'h00;
         else if (r == 1 && allow_special) e = 8'hFF;
         else e = 8'($urandom_range(118, 136));
         vec[i] = {1'($urandom_range(0, 1)), e, 23'($urandom)};
      end
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      reset     = 1'b1;
      in_valid  = 1'b0;
      out_ready = 1'b0;
      in_data   = '0;
      repeat (3) @(negedge clk);
      check_eq("rst_ready_valid", {in_ready_r, out_valid_r, out_last_r, out_special_r}, 4'b1000);
      check_eq("rst_exp_sign", {out_exp_r, out_sign_r}, 12'h000);
      check_eq("rst_mant", out_mant_r, 32'h0);
      reset = 1'b0;

      // Worked example: mantissas 40/80/20/C0, exponent 1.
      set_vec(32'h3F800000, 32'h40000000, 32'h3F000000, 32'hC0400000);
      run_vector(0, 0, 1'b0);
      // Round-up from 7F to 80.
      set_vec(32'h3FFF0000, 32'h40000000, 32'h00000000, 32'h00000000);
      run_vector(0, 0, 1'b0);
      // Rounding overflow saturates at the vector maximum.
      set_vec(32'h3FFFFFFF, 32'h3F800000, 32'h3E000000, 32'h00000000);
      run_vector(0, 0, 1'b0);
      // All zero, then Inf in one lane.
      set_vec(32'h0, 32'h0, 32'h0, 32'h0);
      run_vector(0, 0, 1'b0);
      set_vec(32'h3F800000, 32'h7F800000, 32'hBF000000, 32'h00000000);
      run_vector(0, 0, 1'b0);
      // Long stall in drain, then gaps in fill.
      set_vec(32'h3F800000, 32'h40000000, 32'h3F000000, 32'hC0400000);
      run_vector(0, 5, 1'b0);
      run_vector(4, 0, 1'b0);

      // Reset in the middle of fill: the partial beat must be discarded.
      @(negedge clk);
      in_valid = 1'b1;
      in_data  = {4{32'h7F000000}};
      @(negedge clk);
      in_valid = 1'b0;
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      check_eq("midfill_rst", {in_ready_r, out_valid_r}, 2'b10);
      set_vec(32'h3F800000, 32'h3FC00000, 32'h00000000, 32'h3E800000);
      run_vector(0, 0, 1'b0);

      // Reset after the first output beat, then a fresh vector.
      rand_vec(1'b0);
      run_vector(1, 0, 1'b1);
      set_vec(32'h3FFF0000, 32'h40000000, 32'h00000000, 32'h00000000);
      run_vector(0, 0, 1'b0);

      for (int k = 0; k < 40; k++) begin
         rand_vec(k % 3 == 0);
         run_vector(2, 0, 1'b0);
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/bfp_block_normalizer.md
Name: bfp_block_normalizer

Overview:
Successor to the per-beat largest-exponent stage. It converts a whole vector of V = P*BEATS IEEE-style floats, arriving P lanes per beat, into block floating point. The shared exponent is the maximum over the entire vector, not just one beat. Each mantissa is right-aligned to that exponent, optionally rounded, and drained with valid/ready backpressure. It sits between the input float stream and the BFP dot-product datapath.

Parameters:
P, 4, lanes per beat
BEATS, 2, beats per vector (V = P*BEATS), >= 1
BIT, 32, input float width
FPM, 23, input fraction bits
BFPM, 8, output mantissa magnitude bits, including the hidden one; requires BFPM <= FPM
RND, 1, 1 = round-half-up on the first dropped bit with saturation; 0 = truncate
EXP (localparam), BIT-FPM-1, exponent field width; BIAS = 2**(EXP-1)-1

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high
in_valid  in  1  input beat valid
in_ready  out  1  block can accept a beat
in_data  in  P*BIT  lane j = in_data[j*BIT +: BIT]
out_valid  out  1  output beat valid
out_ready  in  1  downstream accepts beat
out_sign  out  P  lane sign bits
out_mant  out  P*BFPM  lane j magnitude = out_mant[j*BFPM +: BFPM]
out_exp  out  EXP  shared exponent, unbiased, two's complement
out_last  out  1  high on the final beat of a vector
out_special  out  1  vector contained Inf/NaN; constant across all beats of that vector

Behaviour:
- Clock port is clk; reset is synchronous and active-high. All state is updated on posedge clk.
- Reset values: FSM=FILL; beat counter=0; running max=0; special flag=0. Outputs: in_ready=1, out_valid=0, out_last=0, out_special=0, out_exp=0, out_sign=0, out_mant=0. The buffer contents are don't-care.
- FSM has two states, FILL and DRAIN. There is a single buffer, so fill and drain do not overlap.
- FILL behaviour:
  - in_ready=1 and out_valid=0.
  - On in_valid&&in_ready: store the beat in buffer[cnt] and update the running max with each lane's biased exponent field e. Lanes with e==0 (zero/denormal) do not contribute. Lanes with e==all-ones set the special flag and do not contribute.
  - cnt increments. When cnt reaches BEATS-1 on an accept: cnt returns to 0, the max is latched into the shared-exponent register, and the FSM moves to DRAIN next cycle.
  - in_valid low leaves state unchanged, so gaps between beats are allowed.
- DRAIN behaviour:
  - in_ready=0 and out_valid=1.
  - Outputs are a function of buffer[cnt] and the registered max. First output is valid the cycle after the last input beat is accepted.
  - On out_valid&&out_ready: cnt increments. On the last beat (out_last=1, cnt==BEATS-1): cnt returns to 0, the max and special flag clear, and the FSM goes to FILL.
  - out_ready low holds every output stable.
- Per-lane conversion:
  - m = {1, frac[FPM-1 -: BFPM-1]}, BFPM bits; sh = max - e.
  - If e==0 or e==all-ones: mant=0, sign is passed through.
  - If sh >= BFPM: mant=0.
  - Otherwise mant = m >> sh. With RND=1, add 1 when the first dropped bit is set (for sh==0, that bit is frac[FPM-BFPM]). If the result reaches 2**BFPM, saturate to all-ones.
- Shared exponent: out_exp = max - BIAS as an EXP-bit two's-complement value. If no lane contributed (max==0), out_exp=0 and all mantissas are 0.
- Reset asserted mid-FILL or mid-DRAIN aborts the vector: reset values apply the next cycle and no partial beats are emitted.
- Throughput: one vector per 2*BEATS cycles at best.

Test Plan:
1. P=4, BEATS=2, BFPM=8, RND=1. Beat0 = {3F800000, 40000000, 3F000000, C0400000}, beat1 all 0 -> out_exp=1. Beat0 mant = {40, 80, 20, C0}, sign = 4'b1000. Beat1 mant all 0 with out_last=1. First out_valid occurs 1 cycle after the second input accept.
2. Lane 3FFF0000 with another lane at 40000000 (sh=1) -> RND=1 gives mant=80; rerun with RND=0 -> mant=7F.
3. Lane 3FFFFFFF as the vector max (sh=0), RND=1 -> rounding overflows and saturates to FF; out_exp=0.
4. All-zero vector -> out_exp=0, all mant 0, out_special=0. One lane 7F800000 -> out_special=1 on both beats and that lane's mant=0.
5. Hold out_ready low 5 cycles in DRAIN -> outputs stable and in_ready=0. Insert in_valid gaps in FILL -> same result as the gapless case.
6. Assert reset after the first output beat -> next cycle out_valid=0, in_ready=1, out_exp=0. A new vector then converts correctly.
